// File: rtl/cvbs_pkg.sv
// Purpose : shared encodings and NTSC 240p defaults for the composite-video output path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cvbs_pkg;

  localparam int CLK_SPEED            = 27_000_000;

  localparam int NTSC_LINES_PER_FRAME = 262;
  localparam int NTSC_VSYNC_LINES     = 3;
  localparam int NTSC_TOP_BLANK_LINES = 16;
  localparam int NTSC_ACTIVE_LINES    = 240;
  localparam int NTSC_LINE_W          = 9;

  typedef enum logic [1:0] {
    LT_VSYNC  = 2'd0,
    LT_BLANK  = 2'd1,
    LT_ACTIVE = 2'd2
  } line_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cvbs_line_classifier.sv
// Purpose : maps a scanline number to its line type and active-line index.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : i_line        scanline number 0..LINES_PER_FRAME-1
//           o_type        VSYNC / BLANK / ACTIVE
//           o_active_idx  i_line-(V+T) on ACTIVE lines, else 0
module cvbs_line_classifier
  import cvbs_pkg::*;
#(
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int VSYNC_LINES     = NTSC_VSYNC_LINES,
  parameter int TOP_BLANK_LINES = NTSC_TOP_BLANK_LINES,
  parameter int ACTIVE_LINES    = NTSC_ACTIVE_LINES,
  parameter int LINE_W          = NTSC_LINE_W
) (
  input  logic [LINE_W-1:0] i_line,
  output line_type_e        o_type,
  output logic [LINE_W-1:0] o_active_idx
);

  localparam int P_VT  = VSYNC_LINES + TOP_BLANK_LINES;
  localparam int P_VTA = P_VT + ACTIVE_LINES;
  localparam logic [LINE_W-1:0] P_VT_W = LINE_W'(P_VT);

  // Integer compares avoid wrap when V+T+A equals 2**LINE_W.
  int w_line_int;
  assign w_line_int = int'(i_line);

  always_comb begin
    o_type       = LT_BLANK;
    o_active_idx = '0;
    if (w_line_int < VSYNC_LINES) begin
      o_type = LT_VSYNC;
    end else if (w_line_int < P_VT) begin
      o_type = LT_BLANK;
    end else if (w_line_int < P_VTA) begin
      o_type       = LT_ACTIVE;
      o_active_idx = i_line - P_VT_W;
    end
  end

endmodule

// File: rtl/cvbs_frame_sequencer.sv
// Purpose : frame scheduler; issues one classified command per scanline, waits for line_done.
// Latency : cmd_valid rises 1 cycle after enable (IDLE) or line_done; drops 1 cycle after handshake.
// Backpressure: cmd_ready low stalls in ISSUE with all outputs held.
// Ports   : i_clk/i_reset_n clock and async active-low reset (release expected synchronous)
//           i_enable run request, looked at only in IDLE and at the last line_done of a frame
//           o_cmd_valid/i_cmd_ready, o_cmd_type, o_cmd_active_idx  line command handshake
//           i_line_done  end-of-line pulse; o_frame_start  line-0 command accepted
//           o_line_count current line; o_busy not IDLE; o_err_spurious sticky stray line_done
module cvbs_frame_sequencer
  import cvbs_pkg::*;
#(
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int VSYNC_LINES     = NTSC_VSYNC_LINES,
  parameter int TOP_BLANK_LINES = NTSC_TOP_BLANK_LINES,
  parameter int ACTIVE_LINES    = NTSC_ACTIVE_LINES,
  parameter int LINE_W          = NTSC_LINE_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [1:0]        o_cmd_type,
  output logic [LINE_W-1:0] o_cmd_active_idx,
  input  logic              i_line_done,
  output logic              o_frame_start,
  output logic [LINE_W-1:0] o_line_count,
  output logic              o_busy,
  output logic              o_err_spurious
);

  if ((VSYNC_LINES + TOP_BLANK_LINES + ACTIVE_LINES > LINES_PER_FRAME) ||
      (VSYNC_LINES < 1) || ((2 ** LINE_W) < LINES_PER_FRAME)) begin : g_bad_params
    $fatal(1, "cvbs_frame_sequencer: inconsistent line parameters");
  end

  localparam logic [LINE_W-1:0] P_LAST = LINE_W'(LINES_PER_FRAME - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line_count, w_line_nxt;
  logic              r_cmd_valid, r_frame_start, r_busy, r_err_spurious;
  line_type_e        r_cmd_type, w_cls_type;
  logic [LINE_W-1:0] r_cmd_active_idx, w_cls_idx;
  logic              w_handshake, w_spurious;

  assign w_handshake = (r_state == ST_ISSUE) && i_cmd_ready;
  // A line_done coinciding with the handshake is still spurious: the line has not started.
  assign w_spurious  = i_line_done && (r_state != ST_WAIT_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line_count;
    case (r_state)
      ST_IDLE: begin
        w_line_nxt = '0;
        if (i_enable) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (i_cmd_ready) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_line_done) begin
          if (r_line_count == P_LAST) begin
            // Frame boundary: the only point besides IDLE where enable is honoured.
            w_line_nxt  = '0;
            w_state_nxt = i_enable ? ST_ISSUE : ST_IDLE;
          end else begin
            w_line_nxt  = r_line_count + LINE_W'(1);
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_line_nxt  = '0;
      end
    endcase
  end

  // Classify the upcoming line so the command fields are registered alongside cmd_valid.
  cvbs_line_classifier #(
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .VSYNC_LINES     (VSYNC_LINES),
    .TOP_BLANK_LINES (TOP_BLANK_LINES),
    .ACTIVE_LINES    (ACTIVE_LINES),
    .LINE_W          (LINE_W)
  ) u_classifier (
    .i_line       (w_line_nxt),
    .o_type       (w_cls_type),
    .o_active_idx (w_cls_idx)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // frame_start is registered, so it is high in the cycle right after the line-0 handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_line_count     <= '0;
      r_cmd_valid      <= 1'b0;
      r_cmd_type       <= LT_VSYNC;
      r_cmd_active_idx <= '0;
      r_frame_start    <= 1'b0;
      r_busy           <= 1'b0;
      r_err_spurious   <= 1'b0;
    end else begin
      r_line_count     <= w_line_nxt;
      r_cmd_valid      <= (w_state_nxt == ST_ISSUE);
      r_cmd_type       <= w_cls_type;
      r_cmd_active_idx <= w_cls_idx;
      r_frame_start    <= w_handshake && (r_line_count == '0);
      r_busy           <= (w_state_nxt != ST_IDLE);
      r_err_spurious   <= r_err_spurious | w_spurious;
    end
  end

  assign o_cmd_valid      = r_cmd_valid;
  assign o_cmd_type       = r_cmd_type;
  assign o_cmd_active_idx = r_cmd_active_idx;
  assign o_frame_start    = r_frame_start;
  assign o_line_count     = r_line_count;
  assign o_busy           = r_busy;
  assign o_err_spurious   = r_err_spurious;

endmodule

// File: tb/tb_cvbs_frame_sequencer.sv
module tb_cvbs_frame_sequencer;
  import cvbs_pkg::*;

  localparam int LPF = NTSC_LINES_PER_FRAME;
  localparam int V   = NTSC_VSYNC_LINES;
  localparam int T   = NTSC_TOP_BLANK_LINES;
  localparam int A   = NTSC_ACTIVE_LINES;
  localparam int LW  = NTSC_LINE_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          line_done = 1'b0;
  logic          cmd_valid, frame_start, busy, err_spurious;
  logic [1:0]    cmd_type;
  logic [LW-1:0] cmd_active_idx, line_count;

  int n_checks = 0;
  int n_fail   = 0;
  int m_line   = 0;

  typedef struct packed {
    logic [LW-1:0] line;
    logic [1:0]    typ;
    logic [LW-1:0] idx;
    logic          fs;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  always #5 clk = ~clk;

  cvbs_frame_sequencer dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_enable         (enable),
    .o_cmd_valid      (cmd_valid),
    .i_cmd_ready      (cmd_ready),
    .o_cmd_type       (cmd_type),
    .o_cmd_active_idx (cmd_active_idx),
    .i_line_done      (line_done),
    .o_frame_start    (frame_start),
    .o_line_count     (line_count),
    .o_busy           (busy),
    .o_err_spurious   (err_spurious)
  );

  function automatic rec_t model(input int l);
    rec_t r;
    r.line = LW'(l);
    r.idx  = '0;
    r.fs   = (l == 0);
    if (l < V)              r.typ = 2'd0;
    else if (l < V + T)     r.typ = 2'd1;
    else if (l < V + T + A) begin r.typ = 2'd2; r.idx = LW'(l - (V + T)); end
    else                    r.typ = 2'd1;
    return r;
  endfunction

  // Acts as the line generator for one line: accept the command, then line_done after delay.
  task automatic serve_line(input int delay, output bit ok);
    rec_t o;
    int   t = 0;
    cmd_ready = 1'b1;
    while (cmd_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (cmd_valid !== 1'b1) begin ok = 1'b0; return; end
    o.line = line_count; o.typ = cmd_type; o.idx = cmd_active_idx;
    @(negedge clk);
    o.fs = frame_start;
    obs_q.push_back(o);
    repeat (delay - 1) @(negedge clk);
    line_done = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; cmd_ready = 1'b0; line_done = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0 || err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b busy=%b fs=%b err=%b required all 0", cmd_valid, busy, frame_start, err_spurious);
    end
    n_checks++;
    if (line_count !== '0 || cmd_type !== 2'd0 || cmd_active_idx !== '0) begin
      n_fail++; $display("FAIL reset_cmd: line=%0d type=%0d idx=%0d required 0/0/0", line_count, cmd_type, cmd_active_idx);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_enable: busy=%b valid=%b required 0/0", busy, cmd_valid);
    end
  endtask

  task automatic test_two_frames();
    int   spot_l[6] = '{0, 3, 18, 19, 258, 259};
    int   spot_t[6] = '{0, 1, 1, 2, 2, 1};
    int   spot_i[6] = '{0, 0, 0, 0, 239, 0};
    int   hs = 0, fs_cnt = 0;
    bit   ok;
    rec_t e, o;
    enable = 1'b1; m_line = 0;
    for (int i = 0; i < 2 * LPF; i++) begin
      exp_q.push_back(model(m_line));
      m_line = (m_line + 1) % LPF;
      serve_line(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL frames_timeout: cmd_valid=0 at cmd %0d, required 1", i); break; end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      hs++; if (o.fs) fs_cnt++;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL frames_cmd %0d: line=%0d type=%0d idx=%0d fs=%b required line=%0d type=%0d idx=%0d fs=%b",
                           i, o.line, o.typ, o.idx, o.fs, e.line, e.typ, e.idx, e.fs);
      end
      for (int s = 0; s < 6; s++) begin
        if (i < LPF && i == spot_l[s]) begin
          n_checks++;
          if (int'(o.typ) != spot_t[s] || int'(o.idx) != spot_i[s]) begin
            n_fail++; $display("FAIL spot_line %0d: type=%0d idx=%0d required type=%0d idx=%0d", i, o.typ, o.idx, spot_t[s], spot_i[s]);
          end
        end
      end
    end
    n_checks++;
    if (hs != 2 * LPF || fs_cnt != 2) begin
      n_fail++; $display("FAIL frames_count: handshakes=%0d frame_starts=%0d required %0d and 2", hs, fs_cnt, 2 * LPF);
    end
  endtask

  task automatic test_enable_drop();
    bit   ok;
    int   extra = 0;
    rec_t e, o;
    for (int i = 0; i < LPF; i++) begin
      if (i == 100) enable = 1'b0;
      exp_q.push_back(model(m_line));
      m_line = (m_line + 1) % LPF;
      serve_line(3, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL drop_timeout: cmd_valid=0 at line %0d, required 1", i); break; end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL drop_cmd: line=%0d type=%0d idx=%0d fs=%b required line=%0d type=%0d idx=%0d fs=%b",
                           o.line, o.typ, o.idx, o.fs, e.line, e.typ, e.idx, e.fs);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || line_count !== '0) begin
      n_fail++; $display("FAIL drop_idle: busy=%b line=%0d required 0/0", busy, line_count);
    end
    repeat (20) begin @(negedge clk); if (cmd_valid !== 1'b0) extra++; end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL drop_no_cmd: cmd_valid high %0d cycles, required 0", extra); end
  endtask

  task automatic test_spurious();
    int t = 0;
    cmd_ready = 1'b0;
    line_done = 1'b1; @(negedge clk); line_done = 1'b0; @(negedge clk);
    n_checks++;
    if (err_spurious !== 1'b1 || line_count !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_idle: err=%b line=%0d busy=%b required 1/0/0", err_spurious, line_count, busy);
    end
    enable = 1'b1;
    while (cmd_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    line_done = 1'b1; @(negedge clk); line_done = 1'b0; @(negedge clk);
    n_checks++;
    if (cmd_valid !== 1'b1 || line_count !== '0 || err_spurious !== 1'b1) begin
      n_fail++; $display("FAIL spur_issue: valid=%b line=%0d err=%b required 1/0/1", cmd_valid, line_count, err_spurious);
    end
    // line_done on the handshake cycle: handshake must still complete.
    cmd_ready = 1'b1; line_done = 1'b1; @(negedge clk);
    cmd_ready = 1'b0; line_done = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || frame_start !== 1'b1 || line_count !== '0) begin
      n_fail++; $display("FAIL spur_handshake: valid=%b busy=%b fs=%b line=%0d required 0/1/1/0", cmd_valid, busy, frame_start, line_count);
    end
    line_done = 1'b1; @(negedge clk); line_done = 1'b0;
    m_line = 1;
    n_checks++;
    if (line_count !== LW'(1) || cmd_valid !== 1'b1 || err_spurious !== 1'b1) begin
      n_fail++; $display("FAIL spur_advance: line=%0d valid=%b err=%b required 1/1/1", line_count, cmd_valid, err_spurious);
    end
  endtask

  task automatic test_stall();
    rec_t e, o;
    bit   ok;
    cmd_ready = 1'b0;
    e = model(m_line);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_type !== e.typ || cmd_active_idx !== e.idx || line_count !== e.line) begin
        n_fail++; $display("FAIL stall_hold cyc %0d: valid=%b type=%0d idx=%0d line=%0d required 1/%0d/%0d/%0d",
                           c, cmd_valid, cmd_type, cmd_active_idx, line_count, e.typ, e.idx, e.line);
      end
    end
    exp_q.push_back(e);
    m_line = (m_line + 1) % LPF;
    serve_line(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout: cmd_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL stall_cmd: line=%0d type=%0d idx=%0d fs=%b required line=%0d type=%0d idx=%0d fs=%b",
                           o.line, o.typ, o.idx, o.fs, e.line, e.typ, e.idx, e.fs);
      end
    end
    n_checks++;
    if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b required 1", err_spurious); end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   t = 0;
    rec_t e, o;
    while (m_line < 150) begin
      exp_q.push_back(model(m_line));
      m_line = m_line + 1;
      serve_line(2, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_pre_timeout: cmd_valid=0 required 1"); break; end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL rst_pre_cmd: line=%0d type=%0d idx=%0d fs=%b required line=%0d type=%0d idx=%0d fs=%b",
                           o.line, o.typ, o.idx, o.fs, e.line, e.typ, e.idx, e.fs);
      end
    end
    cmd_ready = 1'b1;
    while (cmd_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || line_count !== LW'(150)) begin
      n_fail++; $display("FAIL rst_wait_state: valid=%b busy=%b line=%0d required 0/1/150", cmd_valid, busy, line_count);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || line_count !== '0 || err_spurious !== 1'b0 ||
        cmd_type !== 2'd0 || cmd_active_idx !== '0 || frame_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: valid=%b busy=%b line=%0d err=%b type=%0d idx=%0d fs=%b required all 0",
                         cmd_valid, busy, line_count, err_spurious, cmd_type, cmd_active_idx, frame_start);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_line = 0;
    exp_q.push_back(model(m_line));
    m_line = 1;
    serve_line(4, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_restart_timeout: cmd_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("FAIL rst_restart: line=%0d type=%0d idx=%0d fs=%b required line=%0d type=%0d idx=%0d fs=%b",
                           o.line, o.typ, o.idx, o.fs, e.line, e.typ, e.idx, e.fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_enable_drop();
    test_spurious();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
